datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq.sv | 160 ++++++++++++++++
 tb/tb_datapath_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// Sequential ALU datapath: a small register file, a one-cycle ALU and an
// iterative shift-add multiplier, all sequenced by a four-state FSM.
module datapath_seq #(
  parameter int WIDTH = 32,
  parameter int NREG  = 4,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rd,
  input  logic             wr,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]       state;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic             wr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] shl_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum;

  assign busy = (state != S_IDLE);
  assign rd_a = regs[ra];
  assign rd_b = regs[rb];

  always_comb begin
    sum      = a_q + b_q;
    diff     = a_q - b_q;
    shl_full = {{WIDTH{1'b0}}, a_q} << b_q[SW-1:0];
    alu_res  = '0;
    alu_ovf  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLT: alu_res = ($signed(a_q) < $signed(b_q)) ? WIDTH'(1) : '0;
      OP_SLL: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_ovf = |shl_full[2*WIDTH-1:WIDTH];
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // One multiplier bit per cycle: b_q doubles as the low product half and
  // shifts right as hi_q accumulates, so after WIDTH steps {hi_q,b_q} = A*B.
  assign mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Operands are sampled from the pre-load register values.
          if (ld_en) regs[ld_addr] <= ld_data;
          if (start) begin
            a_q   <= rd_a;
            b_q   <= rd_b;
            op_q  <= op;
            rd_q  <= rd;
            wr_q  <= wr;
            hi_q  <= '0;
            cnt_q <= '0;
            state <= (op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          Result   <= alu_res;
          Zero     <= (alu_res == '0);
          Overflow <= alu_ovf;
          if (wr_q) regs[rd_q] <= alu_res;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_MUL: begin
          hi_q  <= mul_sum[WIDTH:1];
          b_q   <= {mul_sum[0], b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state <= S_WB;
        end
        S_WB: begin
          Result   <= b_q;
          Zero     <= (b_q == '0);
          Overflow <= |hi_q;
          if (wr_q) regs[rd_q] <= b_q;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Randomised and directed bench for datapath_seq against an arithmetic
// reference model of the register file and operations.
module tb_datapath_seq;

  localparam int WIDTH = 32;
  localparam int NREG  = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [AW-1:0]    ra = '0;
  logic [AW-1:0]    rb = '0;
  logic [AW-1:0]    rd = '0;
  logic             wr = 1'b0;
  logic             ld_en = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;

  logic [WIDTH-1:0] model_regs [NREG];
  logic [WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  datapath_seq #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ra(ra), .rb(rb), .rd(rd),
    .wr(wr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .done(done), .Result(Result), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: wide signed/unsigned arithmetic, no bit-level datapath.
  function automatic void model_op(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   output logic [WIDTH-1:0] res, output logic ovf);
    longint s;
    logic [63:0] f;
    res = '0;
    ovf = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        s = (o == 3'd0) ? longint'($signed(a)) + longint'($signed(b))
                        : longint'($signed(a)) - longint'($signed(b));
        f = 64'(s);
        res = f[31:0];
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: begin
        f = 64'(a) << b[4:0];
        res = f[31:0];
        ovf = (f[63:32] != 0);
      end
      default: begin
        f = 64'(a) * 64'(b);
        res = f[31:0];
        ovf = (f[63:32] != 0);
      end
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7fff_ffff;
      3: return 32'h8000_0000;
      4: return 32'hffff_ffff;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_load(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    model_regs[addr] = data;
  endtask

  // Issues one operation, optionally with a coincident load (with_ld) and
  // with a start plus load poked mid-operation (poke) that must be ignored.
  task automatic do_op(input logic [2:0] o, input logic [AW-1:0] a_i, input logic [AW-1:0] b_i,
                       input logic [AW-1:0] d_i, input logic w_i, input bit with_ld,
                       input logic [AW-1:0] la, input logic [WIDTH-1:0] lv, input bit poke);
    logic [WIDTH-1:0] eres;
    logic eovf;
    int n;
    int exp_lat;
    model_op(o, model_regs[a_i], model_regs[b_i], eres, eovf);
    exp_lat = (o == 3'd7) ? WIDTH + 1 : 1;
    @(negedge clk);
    start = 1'b1; op = o; ra = a_i; rb = b_i; rd = d_i; wr = w_i;
    ld_en = with_ld; ld_addr = la; ld_data = lv;
    @(posedge clk); #1;
    start = 1'b0; ld_en = 1'b0;
    if (with_ld) model_regs[la] = lv;
    check("busy_after_start", 32'(busy), 32'd1);
    n = 1;
    while (n <= 100) begin
      @(posedge clk); #1;
      if (done) break;
      if (poke && n == 10) begin
        start = 1'b1; op = 3'd0; ra = 2'd3; rb = 2'd3; rd = d_i ^ 2'd1; wr = 1'b1;
        ld_en = 1'b1; ld_addr = d_i ^ 2'd1; ld_data = 32'hdead_beef;
      end
      if (poke && n == 11) begin
        start = 1'b0; ld_en = 1'b0;
      end
      n++;
    end
    check("done_latency", 32'(n), 32'(exp_lat));
    check("result", Result, eres);
    check("zero", 32'(Zero), 32'(eres == 0));
    check("overflow", 32'(Overflow), 32'(eovf));
    if (w_i) model_regs[d_i] = eres;
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
  endtask

  // Reads a register through the datapath as OR r,r with no write-back.
  task automatic check_reg(input logic [AW-1:0] r);
    exp_q.push_back(model_regs[r]);
    do_op(3'd3, r, r, r, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    check("reg_value", Result, exp_q.pop_front());
  endtask

  task automatic reset_dut();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_zero", 32'(Zero), 32'd1);
    check("rst_ovf", 32'(Overflow), 32'd0);
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] ro;
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    reset_dut();
    for (int i = 0; i < NREG; i++) check_reg(2'(i));

    // Basic ADD/SUB with rd aliasing the sources.
    do_load(2'd3, 32'd1);
    do_op(3'd0, 2'd3, 2'd3, 2'd1, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    check_reg(2'd1);
    do_op(3'd1, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    check_reg(2'd1);

    // Signed overflow and SLT on the wrapped value.
    do_load(2'd0, 32'h7fff_ffff);
    do_load(2'd1, 32'd1);
    do_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    do_op(3'd5, 2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    check_reg(2'd3);

    // MUL with overflow; start and load poked mid-MUL are ignored.
    do_load(2'd0, 32'h0001_0000);
    do_load(2'd1, 32'h0001_0000);
    do_op(3'd7, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0, '0, 1'b1);
    check_reg(2'd3);
    check_reg(2'd2);

    // SLL with bits shifted out, then a load coinciding with start.
    do_load(2'd0, 32'hc000_0001);
    do_load(2'd1, 32'd1);
    do_op(3'd6, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    do_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0, 32'd100, 1'b0);
    check_reg(2'd0);

    // 6*7 then reset in the middle of a second MUL.
    do_load(2'd0, 32'd6);
    do_load(2'd1, 32'd7);
    do_op(3'd7, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd7; ra = 2'd0; rb = 2'd1; rd = 2'd3; wr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midmul_rst_busy", 32'(busy), 32'd0);
    check("midmul_rst_done", 32'(done), 32'd0);
    check("midmul_rst_result", Result, 32'd0);
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) check_reg(2'(i));

    // Back-to-back: start held high, second op accepted in the done cycle.
    do_load(2'd2, 32'd5);
    do_load(2'd3, 32'd9);
    @(negedge clk);
    start = 1'b1; op = 3'd0; ra = 2'd2; rb = 2'd3; rd = 2'd0; wr = 1'b1;
    @(posedge clk); #1;
    op = 3'd4; ra = 2'd0; rb = 2'd3; rd = 2'd1; wr = 1'b1;
    @(posedge clk); #1;
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_result1", Result, 32'd14);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy2", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_result2", Result, 32'd14 ^ 32'd9);
    model_regs[0] = 32'd14;
    model_regs[1] = 32'd14 ^ 32'd9;
    check_reg(2'd0);
    check_reg(2'd1);

    // Randomised operations against the model.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) do_load(2'($urandom_range(0, 3)), rand_word());
      ro = 3'($urandom_range(0, 7));
      if (ro == 3'd7 && $urandom_range(0, 2) != 0) ro = 3'($urandom_range(0, 6));
      do_op(ro, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), rand_word(), bit'($urandom_range(0, 4) == 0));
    end
    for (int i = 0; i < NREG; i++) check_reg(2'(i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
